ht_lookup_ctrl: RTL and testbench

- Sequential front-end for the 4-entry associative key/value table (HT).
- Accepts key lookups from a requester via valid/ready and drives the key to the combinational table, then samples hit/value.
- On a miss, fetches the value from a slow backing memory via req/ack, installs key/value in the table at a round-robin victim slot, and returns the value.
- Sits directly upstream of the table, between requester and table/backing memory.

---
 rtl/ht_pkg.sv | 24 ++
 rtl/ht_victim_ptr.sv | 27 ++
 rtl/ht_lookup_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_ht_lookup_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ht_pkg.sv
// ht_pkg: shared definitions for the hash-table lookup controller slice.
// Holds the FSM state encodings, default key/value widths, the table
// geometry (4 entries, 2-bit index) and the statistics counter width.
// The saturating increment helper serves the optional lookup statistics.
package ht_pkg;

    localparam int KW_DEF   = 3;
    localparam int VW_DEF   = 3;
    localparam int NENT_DEF = 4;
    localparam int IDX_W    = 2;
    localparam int CNT_W    = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOOKUP = 3'd1;
    localparam logic [2:0] ST_FETCH  = 3'd2;
    localparam logic [2:0] ST_FILL   = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ht_victim_ptr.sv
// ht_victim_ptr: round-robin replacement pointer for the 4-entry table.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset (pointer returns to 0)
//   i_adv  in   advance the pointer by one (wraps 3 -> 0)
//   o_idx  out  current victim entry index
module ht_victim_ptr
    import ht_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_adv,
    output logic [IDX_W-1:0] o_idx
);

    logic [IDX_W-1:0] r_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_idx <= '0;
        else if (i_adv)
            r_idx <= r_idx + 1'b1;
    end

    assign o_idx = r_idx;

endmodule

// File: rtl/ht_lookup_ctrl.sv
// ht_lookup_ctrl: sequential front-end for the 4-entry key/value table.
// A requester hands in a key (valid/ready); the key is driven to the
// combinational table and the hit/value sampled one cycle later. On a miss
// the value is fetched from backing memory (level req / pulse ack), written
// into the table at the round-robin victim slot and returned to the requester.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready/req_key     lookup request (ready only when idle)
//   rsp_valid/rsp_ready             response handshake
//   rsp_value/rsp_hit               returned value, 1 = served from table
//   ht_key, ht_hit, ht_value        table lookup port
//   ht_wr_en/idx/key/value          one-cycle table install strobe
//   mem_req/mem_addr/mem_ack/mem_data  backing-memory fetch port
// Build option HT_LOOKUP_STATS_EN adds stats_clr (in), hit_cnt and miss_cnt
// (out, 8-bit saturating counts of lookups that hit / missed).
module ht_lookup_ctrl
    import ht_pkg::*;
#(
    parameter int KW   = KW_DEF,
    parameter int VW   = VW_DEF,
    parameter int NENT = NENT_DEF
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [KW-1:0]           req_key,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [VW-1:0]           rsp_value,
    output logic                    rsp_hit,
    output logic [KW-1:0]           ht_key,
    input  logic                    ht_hit,
    input  logic [VW-1:0]           ht_value,
    output logic                    ht_wr_en,
    output logic [$clog2(NENT)-1:0] ht_wr_idx,
    output logic [KW-1:0]           ht_wr_key,
    output logic [VW-1:0]           ht_wr_value,
    output logic                    mem_req,
    output logic [KW-1:0]           mem_addr,
    input  logic                    mem_ack,
    input  logic [VW-1:0]           mem_data
`ifdef HT_LOOKUP_STATS_EN
    ,
    input  logic                    stats_clr,
    output logic [CNT_W-1:0]        hit_cnt,
    output logic [CNT_W-1:0]        miss_cnt
`endif
);

    logic [2:0]              r_state;
    logic [KW-1:0]           r_key;
    logic [VW-1:0]           r_data;
    logic [KW-1:0]           r_ht_key;
    logic                    r_rsp_valid;
    logic [VW-1:0]           r_rsp_value;
    logic                    r_rsp_hit;
    logic                    r_wr_en;
    logic [$clog2(NENT)-1:0] r_wr_idx;
    logic [KW-1:0]           r_wr_key;
    logic [VW-1:0]           r_wr_value;
    logic                    r_mem_req;
    logic [KW-1:0]           r_mem_addr;

    logic                    w_adv;
    logic [IDX_W-1:0]        w_victim;

    // The pointer moves once per completed fill; hits never touch it.
    assign w_adv = (r_state == ST_FILL);

    ht_victim_ptr u_victim (
        .clk   (clk),
        .rst_n (rst_n),
        .i_adv (w_adv),
        .o_idx (w_victim)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_key       <= '0;
            r_data      <= '0;
            r_ht_key    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_value <= '0;
            r_rsp_hit   <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_idx    <= '0;
            r_wr_key    <= '0;
            r_wr_value  <= '0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
        end else begin
            // Table write is a single-cycle strobe.
            r_wr_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_key    <= req_key;
                        r_ht_key <= req_key;
                        r_state  <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (ht_hit) begin
                        r_rsp_value <= ht_value;
                        r_rsp_hit   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_key;
                        r_state    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // mem_ack is only observed here; stray acks elsewhere are dropped.
                    if (mem_ack) begin
                        r_mem_req  <= 1'b0;
                        r_data     <= mem_data;
                        r_wr_en    <= 1'b1;
                        r_wr_idx   <= w_victim;
                        r_wr_key   <= r_key;
                        r_wr_value <= mem_data;
                        r_state    <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    r_rsp_value <= r_data;
                    r_rsp_hit   <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready   = (r_state == ST_IDLE);
    assign rsp_valid   = r_rsp_valid;
    assign rsp_value   = r_rsp_value;
    assign rsp_hit     = r_rsp_hit;
    assign ht_key      = r_ht_key;
    assign ht_wr_en    = r_wr_en;
    assign ht_wr_idx   = r_wr_idx;
    assign ht_wr_key   = r_wr_key;
    assign ht_wr_value = r_wr_value;
    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;

`ifdef HT_LOOKUP_STATS_EN
    logic [CNT_W-1:0] r_hit_cnt;
    logic [CNT_W-1:0] r_miss_cnt;

    // Clear has priority over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (stats_clr) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (r_state == ST_LOOKUP) begin
            if (ht_hit)
                r_hit_cnt  <= sat_inc(r_hit_cnt);
            else
                r_miss_cnt <= sat_inc(r_miss_cnt);
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_ht_lookup_ctrl.sv
module tb_ht_lookup_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready;
    logic [2:0] req_key;
    logic       rsp_valid, rsp_ready;
    logic [2:0] rsp_value;
    logic       rsp_hit;
    logic [2:0] ht_key;
    logic       ht_hit;
    logic [2:0] ht_value;
    logic       ht_wr_en;
    logic [1:0] ht_wr_idx;
    logic [2:0] ht_wr_key, ht_wr_value;
    logic       mem_req;
    logic [2:0] mem_addr;
    logic       mem_ack;
    logic [2:0] mem_data;
`ifdef HT_LOOKUP_STATS_EN
    logic       stats_clr;
    logic [7:0] hit_cnt, miss_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ht_lookup_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_value(rsp_value), .rsp_hit(rsp_hit),
        .ht_key(ht_key), .ht_hit(ht_hit), .ht_value(ht_value),
        .ht_wr_en(ht_wr_en), .ht_wr_idx(ht_wr_idx),
        .ht_wr_key(ht_wr_key), .ht_wr_value(ht_wr_value),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_data(mem_data)
`ifdef HT_LOOKUP_STATS_EN
        , .stats_clr(stats_clr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    // Environment: the associative table the DUT talks to.
    logic [2:0] env_key [4];
    logic [2:0] env_val [4];
    logic       env_vld [4];
    logic       do_preload;

    always @(posedge clk) begin
        if (do_preload) begin
            env_key[0] <= 3'd5; env_val[0] <= 3'd1; env_vld[0] <= 1'b1;
            env_key[1] <= 3'd6; env_val[1] <= 3'd2; env_vld[1] <= 1'b1;
            env_key[2] <= 3'd1; env_val[2] <= 3'd1; env_vld[2] <= 1'b1;
            env_key[3] <= 3'd2; env_val[3] <= 3'd3; env_vld[3] <= 1'b1;
        end else if (ht_wr_en) begin
            env_key[ht_wr_idx] <= ht_wr_key;
            env_val[ht_wr_idx] <= ht_wr_value;
            env_vld[ht_wr_idx] <= 1'b1;
        end
    end

    always_comb begin
        ht_hit   = 1'b0;
        ht_value = 3'd0;
        for (int i = 3; i >= 0; i--)
            if (env_vld[i] === 1'b1 && env_key[i] == ht_key) begin
                ht_hit   = 1'b1;
                ht_value = env_val[i];
            end
    end

    // Reference model: contents of the table as the rules predict them.
    logic [2:0] ref_key [4];
    logic [2:0] ref_val [4];
    int         ref_vic;
    int         cnt_hit, cnt_miss;

    task automatic ref_apply(input logic [2:0] key, input logic [2:0] mdata,
                             output logic hit, output logic [2:0] val,
                             output logic [1:0] idx);
        hit = 1'b0; val = mdata; idx = 2'(ref_vic);
        for (int i = 0; i < 4; i++)
            if (ref_key[i] == key) begin hit = 1'b1; val = ref_val[i]; end
        if (!hit) begin
            ref_key[ref_vic] = key;
            ref_val[ref_vic] = mdata;
            ref_vic = (ref_vic + 1) % 4;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One full transaction; called just after a rising edge with DUT idle.
    task automatic do_req(input logic [2:0] key, input int ack_dly,
                          input logic [2:0] mdata, input int hold,
                          input logic exp_hit, input logic [2:0] exp_val,
                          input logic [1:0] exp_idx);
        chk("idle_ready", req_ready, 1);
        req_valid = 1'b1; req_key = key;
        @(posedge clk); #1;
        req_valid = 1'b0; req_key = 3'($urandom);
        chk("lookup_no_rsp", rsp_valid, 0);
        chk("lookup_ht_key", ht_key, key);
        chk("lookup_busy", req_ready, 0);
        if (exp_hit) begin
            cnt_hit++;
            @(posedge clk); #1;
            chk("hit_rsp_valid", rsp_valid, 1);
            chk("hit_mem_req", mem_req, 0);
            chk("hit_no_wr", ht_wr_en, 0);
        end else begin
            cnt_miss++;
            @(posedge clk); #1;
            chk("fetch_mem_req", mem_req, 1);
            chk("fetch_mem_addr", mem_addr, key);
            for (int i = 0; i < ack_dly; i++) begin
                @(posedge clk); #1;
                chk("fetch_hold_req", mem_req, 1);
                chk("fetch_no_rsp", rsp_valid, 0);
            end
            mem_ack = 1'b1; mem_data = mdata;
            @(posedge clk); #1;
            mem_ack = 1'b0; mem_data = 3'($urandom);
            chk("fill_wr_en", ht_wr_en, 1);
            chk("fill_wr_idx", ht_wr_idx, exp_idx);
            chk("fill_wr_key", ht_wr_key, key);
            chk("fill_wr_val", ht_wr_value, exp_val);
            chk("fill_mem_req_low", mem_req, 0);
            chk("fill_no_rsp", rsp_valid, 0);
            @(posedge clk); #1;
            chk("miss_wr_pulse", ht_wr_en, 0);
            chk("miss_rsp_valid", rsp_valid, 1);
        end
        chk("rsp_value", rsp_value, exp_val);
        chk("rsp_hit", rsp_hit, exp_hit);
        chk("rsp_busy", req_ready, 0);
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1; req_key = ~key;
            rsp_ready = 1'b0;
            @(posedge clk); #1;
            chk("hold_valid", rsp_valid, 1);
            chk("hold_value", rsp_value, exp_val);
            chk("hold_hit", rsp_hit, exp_hit);
            chk("hold_not_ready", req_ready, 0);
            chk("hold_ht_key", ht_key, key);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("done_valid", rsp_valid, 0);
        chk("done_ready", req_ready, 1);
    endtask

    typedef struct {
        logic [2:0] key;
        int         ack_dly;
        logic [2:0] mdata;
        int         hold;
        logic       exp_hit;
        logic [2:0] exp_val;
        logic [1:0] exp_idx;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic       h;
        logic [2:0] v;
        logic [1:0] ix;

        vecs[0] = '{3'd6, 0, 3'd0, 0, 1'b1, 3'd2, 2'd0};
        vecs[1] = '{3'd7, 3, 3'd4, 0, 1'b0, 3'd4, 2'd0};
        vecs[2] = '{3'd7, 0, 3'd0, 0, 1'b1, 3'd4, 2'd0};
        vecs[3] = '{3'd0, 0, 3'd5, 0, 1'b0, 3'd5, 2'd1};
        vecs[4] = '{3'd3, 1, 3'd6, 0, 1'b0, 3'd6, 2'd2};
        vecs[5] = '{3'd4, 2, 3'd7, 0, 1'b0, 3'd7, 2'd3};
        vecs[6] = '{3'd5, 0, 3'd3, 0, 1'b0, 3'd3, 2'd0};
        vecs[7] = '{3'd6, 1, 3'd2, 5, 1'b0, 3'd2, 2'd1};
        vecs[8] = '{3'd4, 0, 3'd0, 5, 1'b1, 3'd7, 2'd0};

        ref_key[0] = 3'd5; ref_val[0] = 3'd1;
        ref_key[1] = 3'd6; ref_val[1] = 3'd2;
        ref_key[2] = 3'd1; ref_val[2] = 3'd1;
        ref_key[3] = 3'd2; ref_val[3] = 3'd3;
        ref_vic = 0; cnt_hit = 0; cnt_miss = 0;

        rst_n = 1'b0; req_valid = 1'b0; req_key = 3'd0;
        rsp_ready = 1'b0; mem_ack = 1'b0; mem_data = 3'd0;
        do_preload = 1'b1;
`ifdef HT_LOOKUP_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        do_preload = 1'b0;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_value", rsp_value, 0);
        chk("rst_rsp_hit", rsp_hit, 0);
        chk("rst_ht_key", ht_key, 0);
        chk("rst_wr_en", ht_wr_en, 0);
        chk("rst_wr_idx", ht_wr_idx, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors: hits, misses, victim wrap, response back-pressure.
        for (int i = 0; i < 9; i++) begin
            ref_apply(vecs[i].key, vecs[i].mdata, h, v, ix);
            do_req(vecs[i].key, vecs[i].ack_dly, vecs[i].mdata, vecs[i].hold,
                   vecs[i].exp_hit, vecs[i].exp_val, vecs[i].exp_idx);
        end

        // Reset during FETCH, then a stale ack after release.
        req_valid = 1'b1; req_key = 3'd1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort_fetch_req", mem_req, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_mem_req", mem_req, 0);
        chk("abort_ready", req_ready, 1);
        chk("abort_wr_en", ht_wr_en, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ref_vic = 0; cnt_hit = 0; cnt_miss = 0;
        mem_ack = 1'b1; mem_data = 3'd6;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk("late_ack_wr_en", ht_wr_en, 0);
        chk("late_ack_mem_req", mem_req, 0);
        chk("late_ack_ready", req_ready, 1);
        @(posedge clk); #1;
        chk("late_ack_wr_en2", ht_wr_en, 0);
        chk("late_ack_rsp", rsp_valid, 0);
        // Victim restarts at 0 after reset.
        ref_apply(3'd1, 3'd2, h, v, ix);
        do_req(3'd1, 0, 3'd2, 0, 1'b0, 3'd2, 2'd0);

        // Randomised traffic against the reference model.
        for (int n = 0; n < 40; n++) begin
            logic [2:0] k, md;
            int         ad, hd;
            k  = 3'($urandom_range(0, 7));
            md = 3'($urandom);
            ad = $urandom_range(0, 3);
            hd = $urandom_range(0, 2);
            ref_apply(k, md, h, v, ix);
            do_req(k, ad, md, hd, h, v, ix);
        end

`ifdef HT_LOOKUP_STATS_EN
        chk("stat_hit_cnt", hit_cnt, (cnt_hit > 255) ? 255 : cnt_hit);
        chk("stat_miss_cnt", miss_cnt, (cnt_miss > 255) ? 255 : cnt_miss);
        stats_clr = 1'b1;
        @(posedge clk); #1;
        stats_clr = 1'b0;
        chk("stat_clr_hit", hit_cnt, 0);
        chk("stat_clr_miss", miss_cnt, 0);
        cnt_hit = 0; cnt_miss = 0;
        // 3 hits + 2 misses after the clear.
        for (int n = 0; n < 3; n++) begin
            ref_apply(ref_key[n], 3'd0, h, v, ix);
            do_req(ref_key[n], 0, 3'd0, 0, h, v, ix);
        end
        for (int n = 0; n < 2; n++) begin
            logic [2:0] k;
            k = 3'd0;
            for (int t = 0; t < 8; t++) begin
                logic found;
                found = 1'b0;
                for (int e = 0; e < 4; e++)
                    if (ref_key[e] == 3'(t)) found = 1'b1;
                if (!found) k = 3'(t);
            end
            ref_apply(k, 3'd5, h, v, ix);
            do_req(k, 1, 3'd5, 0, h, v, ix);
        end
        chk("stat_hit_3", hit_cnt, 3);
        chk("stat_miss_2", miss_cnt, 2);
        stats_clr = 1'b1;
        @(posedge clk); #1;
        stats_clr = 1'b0;
        chk("stat_clr2_hit", hit_cnt, 0);
        chk("stat_clr2_miss", miss_cnt, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
